// File: rtl/minterm_sweeper.sv
// Truth-table streamer: latches an SoP/PoS mask on start and emits one (idx, s) row per accepted cycle.
// Rows start the cycle after start. ready=0 holds the current row. done pulses once after the last transfer.
module minterm_sweeper #(
  parameter int N = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [(2**N)-1:0]   mask_in,
  input  logic                ready,
  output logic                busy,
  output logic                valid,
  output logic [N-1:0]        idx,
  output logic                s,
  output logic [N:0]          ones,
  output logic                done
);
  localparam int M = 2**N;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [N-1:0] IDX_LAST = N'(M - 1);

  logic [1:0]   state_q, state_d;
  logic [M-1:0] mask_q, mask_d;
  logic         mode_q, mode_d;
  logic [N-1:0] idx_q, idx_d;
  logic [N:0]   ones_q, ones_d;
  logic         row_val;

  // PoS rows are the complement of the mask bit at that index.
  assign row_val = mask_q[idx_q] ^ mode_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    ones_d  = ones_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SWEEP;
          mask_d  = mask_in;
          mode_d  = mode;
          idx_d   = '0;
          ones_d  = '0;
        end
      end
      ST_SWEEP: begin
        if (ready) begin
          ones_d = ones_q + (N+1)'(row_val);
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + N'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign valid = (state_q == ST_SWEEP);
  assign done  = (state_q == ST_DONE);
  assign idx   = idx_q;
  assign s     = valid & row_val;
  assign ones  = ones_q;

endmodule

// File: tb/tb_minterm_sweeper.sv
// Drives three sweepers (N=1,3,4) and checks them every cycle against a row-level model, plus literal expectations.
module tb_minterm_sweeper;
  logic        clk = 1'b0;
  logic        rst;
  logic        start [3];
  logic        mode  [3];
  logic        ready [3];
  logic [15:0] mask  [3];
  logic        busy  [3];
  logic        valid [3];
  logic        s     [3];
  logic        done  [3];
  logic [3:0]  idx_w [3];
  logic [4:0]  ones_w[3];

  logic [0:0] idx0;  logic [1:0] ones0;
  logic [2:0] idx1;  logic [3:0] ones1;
  logic [3:0] idx2;  logic [4:0] ones2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // model state per DUT
  int          mv[3] = '{2, 8, 16};
  bit          act[3], dn[3];
  int          pos[3], mones[3];
  logic [15:0] mmask[3];
  bit          mmode[3];

  logic [15:0] seq[3];
  int          nx[3];

  always #5 clk = ~clk;

  minterm_sweeper #(.N(1)) u0 (.clk(clk), .rst(rst), .start(start[0]), .mode(mode[0]),
    .mask_in(mask[0][1:0]), .ready(ready[0]), .busy(busy[0]), .valid(valid[0]),
    .idx(idx0), .s(s[0]), .ones(ones0), .done(done[0]));
  minterm_sweeper #(.N(3)) u1 (.clk(clk), .rst(rst), .start(start[1]), .mode(mode[1]),
    .mask_in(mask[1][7:0]), .ready(ready[1]), .busy(busy[1]), .valid(valid[1]),
    .idx(idx1), .s(s[1]), .ones(ones1), .done(done[1]));
  minterm_sweeper #(.N(4)) u2 (.clk(clk), .rst(rst), .start(start[2]), .mode(mode[2]),
    .mask_in(mask[2]), .ready(ready[2]), .busy(busy[2]), .valid(valid[2]),
    .idx(idx2), .s(s[2]), .ones(ones2), .done(done[2]));

  assign idx_w[0]  = {3'b000, idx0};
  assign idx_w[1]  = {1'b0, idx1};
  assign idx_w[2]  = idx2;
  assign ones_w[0] = {3'b000, ones0};
  assign ones_w[1] = {1'b0, ones1};
  assign ones_w[2] = ones2;

  function automatic bit fval(int d, int k);
    return mmask[d][k] ^ mmode[d];
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        act[d] = 0; dn[d] = 0; mones[d] = 0; pos[d] = 0; mmask[d] = '0; mmode[d] = 0;
      end else if (dn[d]) begin
        dn[d] = 0;
      end else if (act[d]) begin
        if (ready[d]) begin
          mones[d] += int'(fval(d, pos[d]));
          if (pos[d] == mv[d] - 1) begin
            act[d] = 0; dn[d] = 1;
          end else begin
            pos[d]++;
          end
        end
      end else if (start[d]) begin
        act[d] = 1; pos[d] = 0; mones[d] = 0; mmode[d] = mode[d];
        mmask[d] = mask[d] & 16'((32'd1 << mv[d]) - 1);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        bit ok;
        ok = (busy[d] === (act[d] | dn[d])) && (valid[d] === act[d]) && (done[d] === dn[d]) &&
             (ones_w[d] === 5'(mones[d]));
        if (act[d]) ok = ok && (idx_w[d] === 4'(pos[d])) && (s[d] === fval(d, pos[d]));
        tests++;
        if (!ok) begin
          fails++;
          $display("FAIL model dut%0d cyc%0d: got busy=%b valid=%b idx=%0d s=%b ones=%0d done=%b required busy=%b valid=%b idx=%0d s=%b ones=%0d done=%b",
                   d, cyc, busy[d], valid[d], idx_w[d], s[d], ones_w[d], done[d],
                   act[d] | dn[d], act[d], pos[d], fval(d, pos[d]), mones[d], dn[d]);
        end
        if (valid[d] === 1'b1 && ready[d] === 1'b1) begin
          seq[d][idx_w[d]] = s[d];
          nx[d]++;
        end
      end
    end
  end

  task automatic check(string nm, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, a, e);
    end
  endtask

  // stall: 0 none, 1 one stall each at idx 3 and 6, 2 random; poke: start pulses + input churn mid-sweep
  task automatic sweep(int d, bit md, logic [15:0] mk, int stall, bit poke, output int off);
    int e0;
    bit st3, st6;
    st3 = 0; st6 = 0; off = -1;
    seq[d] = '0; nx[d] = 0;
    @(posedge clk); #2;
    start[d] = 1'b1; mode[d] = md; mask[d] = mk; ready[d] = 1'b1;
    @(posedge clk); #2;
    start[d] = 1'b0; e0 = cyc;
    for (int k = 0; k < 300; k++) begin
      if (done[d] === 1'b1) begin
        off = cyc - e0;
        if (poke) start[d] = 1'b1;
        break;
      end
      case (stall)
        1: begin
          if (valid[d] && idx_w[d] == 4'd3 && !st3) begin ready[d] = 1'b0; st3 = 1; end
          else if (valid[d] && idx_w[d] == 4'd6 && !st6) begin ready[d] = 1'b0; st6 = 1; end
          else ready[d] = 1'b1;
        end
        2: ready[d] = ($urandom_range(0, 3) != 0);
        default: ready[d] = 1'b1;
      endcase
      if (poke) begin
        start[d] = (k == 2 || k == 4);
        if (k == 1) begin mask[d] = 16'hFFFF; mode[d] = ~md; end
      end
      @(posedge clk); #2;
    end
    if (off < 0) begin
      tests++; fails++;
      $display("FAIL sweep_timeout dut%0d: got no done required done", d);
    end
    @(posedge clk); #2;
    start[d] = 1'b0; ready[d] = 1'b1;
  endtask

  initial begin
    int off;
    bit saw;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start[d] = 0; mode[d] = 0; ready[d] = 1; mask[d] = '0; seq[d] = '0; nx[d] = 0;
    end
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b1;
    check("reset_outputs", {26'd0, busy[1], valid[1], s[1], done[1], ones_w[1][0], idx_w[1][0]}, 32'd0);
    check("reset_ones", 32'(ones_w[2]), 32'd0);
    rst = 1'b0;

    // done appears M edges after the start edge, i.e. the (M+1)th cycle after start
    sweep(1, 1'b0, 16'h00E4, 0, 0, off);
    check("sop_rows", 32'(seq[1][7:0]), 32'h0E4);
    check("sop_done_off", 32'(off), 32'd8);
    check("sop_ones", 32'(ones_w[1]), 32'd4);

    sweep(1, 1'b1, 16'h00E4, 0, 0, off);
    check("pos_rows", 32'(seq[1][7:0]), 32'h01B);
    check("pos_done_off", 32'(off), 32'd8);
    check("pos_ones", 32'(ones_w[1]), 32'd4);

    sweep(1, 1'b0, 16'h00E4, 1, 0, off);
    check("stall_rows", 32'(seq[1][7:0]), 32'h0E4);
    check("stall_xfers", 32'(nx[1]), 32'd8);
    check("stall_done_off", 32'(off), 32'd10);

    sweep(1, 1'b0, 16'h00E4, 0, 1, off);
    check("capture_rows", 32'(seq[1][7:0]), 32'h0E4);
    check("capture_done_off", 32'(off), 32'd8);
    check("start_in_done_ignored", 32'(busy[1]), 32'd0);

    // abort mid-sweep
    @(posedge clk); #2;
    start[1] = 1'b1; mode[1] = 1'b0; mask[1] = 16'h00E4; ready[1] = 1'b1;
    @(posedge clk); #2;
    start[1] = 1'b0;
    for (int k = 0; k < 20 && !(valid[1] && idx_w[1] == 4'd4); k++) begin
      @(posedge clk); #2;
    end
    check("reached_idx4", {31'd0, valid[1]}, 32'd1);
    rst = 1'b1; start[1] = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0; start[1] = 1'b0;
    check("abort_outputs", {23'd0, busy[1], valid[1], s[1], done[1], ones_w[1], 4'(idx_w[1])} & 32'h1FF, 32'd0);
    saw = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #2;
      saw |= done[1];
    end
    check("abort_no_done", {31'd0, saw}, 32'd0);

    sweep(1, 1'b0, 16'h00E4, 0, 0, off);
    check("fresh_rows", 32'(seq[1][7:0]), 32'h0E4);
    check("fresh_xfers", 32'(nx[1]), 32'd8);

    sweep(0, 1'b0, 16'h0001, 0, 0, off);
    check("n1_rows", 32'(seq[0][1:0]), 32'h1);
    check("n1_ones", 32'(ones_w[0]), 32'd1);
    check("n1_done_off", 32'(off), 32'd2);

    sweep(2, 1'b0, 16'hFFFF, 0, 0, off);
    check("n4_ones", 32'(ones_w[2]), 32'd16);
    check("n4_done_off", 32'(off), 32'd16);

    for (int r = 0; r < 8; r++) begin
      int d;
      d = $urandom_range(0, 2);
      sweep(d, 1'($urandom_range(0, 1)), 16'($urandom), 2, 1'($urandom_range(0, 1)), off);
      check("rand_xfers", 32'(nx[d]), 32'(mv[d]));
    end

    @(posedge clk); #2;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
